// File: rtl/bsg_manycore_host_req_arbiter.sv
// bsg_manycore_host_req_arbiter: credit-limited round-robin host request arbiter with fence drain; BSG_HOST_REQ_ARBITER_STALL_PROFILE_EN adds stall_cycles_o.
module bsg_manycore_host_req_arbiter #(
  parameter int num_req_p      = 2,
  parameter int packet_width_p = 128,
  parameter int max_credits_p  = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  input  logic [num_req_p*packet_width_p-1:0]  req_data_i,
  output logic [num_req_p-1:0]                 req_yumi_o,
  output logic                                 out_v_o,
  output logic [packet_width_p-1:0]            out_data_o,
  input  logic                                 out_ready_i,
  input  logic                                 credit_return_i,
  input  logic                                 fence_i,
  output logic                                 fence_done_o,
  output logic [$clog2(max_credits_p+1)-1:0]   credits_avail_o,
  output logic [$clog2(num_req_p)-1:0]         owner_o,
  output logic                                 credit_err_o
`ifdef BSG_HOST_REQ_ARBITER_STALL_PROFILE_EN
  ,output logic [31:0]                         stall_cycles_o
`endif
);
  localparam int lg_lp = $clog2(num_req_p);
  localparam int cw_lp = $clog2(max_credits_p+1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  state_e state;
  logic [lg_lp-1:0] gnt, idx;
  logic any, full, hs;
  assign any  = |req_v_i;
  assign full = credits_avail_o == cw_lp'(max_credits_p);
  assign hs   = out_v_o & out_ready_i;
  // Walk backwards so the first valid requester after owner_o wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = num_req_p; i >= 1; i--) begin
      idx = lg_lp'((int'(owner_o) + i) % num_req_p);
      if (req_v_i[idx]) gnt = idx;
    end
  end
  always_comb begin
    out_data_o = req_data_i[packet_width_p-1:0];
    for (int k = 1; k < num_req_p; k++)
      if (gnt == lg_lp'(k)) out_data_o = req_data_i[k*packet_width_p +: packet_width_p];
  end
  assign out_v_o      = ~reset_i & (state != DRAIN) & any & (credits_avail_o != '0) & ~fence_i;
  assign req_yumi_o   = num_req_p'(hs) << gnt;
  assign fence_done_o = ~reset_i & fence_i & full;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= IDLE;
      credits_avail_o <= cw_lp'(max_credits_p);
      owner_o         <= lg_lp'(num_req_p-1);
      credit_err_o    <= 1'b0;
    end else begin
      state <= fence_i ? DRAIN : (state != DRAIN && any) ? ISSUE : IDLE;
      if (hs & ~credit_return_i) credits_avail_o <= credits_avail_o - cw_lp'(1);
      else if (credit_return_i & ~hs & full) credit_err_o <= 1'b1;
      else if (credit_return_i & ~hs) credits_avail_o <= credits_avail_o + cw_lp'(1);
      if (hs) owner_o <= gnt;
    end
  end
`ifdef BSG_HOST_REQ_ARBITER_STALL_PROFILE_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) stall_cycles_o <= '0;
    else if (any & ~hs & ~&stall_cycles_o) stall_cycles_o <= stall_cycles_o + 32'd1;
  end
`endif
endmodule
